// File: rtl/matrix_pkg.sv
// matrix_pkg
// Shared definitions for the LED matrix scan path: the matrix geometry,
// the scan driver state encoding, and small helpers that turn a row index
// into a row-select pattern and pull one line out of a packed frame.
// The line-preset stages use the same geometry constants, so the frame
// layout (line r at bits [5r+4:5r]) is defined in one place.
package matrix_pkg;

  localparam int ROWS    = 7;
  localparam int COLS    = 5;
  localparam int ROW_W   = 3;
  localparam int FRAME_W = ROWS * COLS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  // One-hot active-low row select; an out-of-range index selects nothing.
  function automatic logic [ROWS-1:0] row_sel_n(input logic [ROW_W-1:0] r);
    return ~(ROWS'(1) << r);
  endfunction

  // Column pattern of line r inside a packed frame; out-of-range gives 0.
  function automatic logic [COLS-1:0] line_of(input logic [FRAME_W-1:0] f,
                                               input logic [ROW_W-1:0]   r);
    logic [COLS-1:0] v;
    v = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (r == ROW_W'(i)) begin
        v = f[i*COLS +: COLS];
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/matrix_scan_driver_row_timer.sv
// row_timer
// Slot counter for one row slot of the matrix scan. Counts 0..DIV-1 while
// run_i is high and sits at 0 otherwise, so every slot starts from a clean
// count when scanning (re)starts.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   run_i       - count this clock; low clears the count to 0
//   tc_o        - count is at DIV-1 (last clock of the slot)
//   blank_end_o - count is at BLANK-1, so the next clock is the first
//                 driven clock of the slot (never set when BLANK = 0)
module row_timer #(
  parameter int DIV   = 50000,
  parameter int BLANK = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic tc_o,
  output logic blank_end_o
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o = (cnt_q == W'(DIV - 1));

  // With no blank phase there is nothing to end, and BLANK-1 would not be
  // a meaningful count value.
  if (BLANK == 0) begin : g_no_blank
    assign blank_end_o = 1'b0;
  end else begin : g_blank
    assign blank_end_o = (cnt_q == W'(BLANK - 1));
  end

  // Terminal count folds back to 0 explicitly so the counter never leaves
  // 0..DIV-1, even when DIV is not a power of two.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || tc_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver
// Multiplexed 7x5 LED matrix scanner. Each row gets a slot of DIV clocks:
// BLANK clocks with all rows off (ghosting guard) followed by DIV-BLANK
// clocks driving that row's columns. The frame is latched only when a scan
// starts and when row 6 wraps to row 0, so the picture never tears.
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   en          - scan enable; low keeps the display dark
//   frame[34:0] - line r at frame[5r+4:5r], bit c = column c
//   row_n[6:0]  - one-hot active-low row select
//   col[4:0]    - active-high column data for the selected row
//   frame_start - one-clock pulse on the first clock of each latched frame
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [FRAME_W-1:0] frame,
  output logic [ROWS-1:0]    row_n,
  output logic [COLS-1:0]    col,
  output logic               frame_start
);

  // A slot opens in BLANK unless there is no blank phase at all.
  localparam scan_state_e SLOT_START = (BLANK == 0) ? ST_DRIVE : ST_BLANK;

  scan_state_e        state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [FRAME_W-1:0] latch_q, latch_d;
  logic [ROWS-1:0]    row_n_q, row_n_d;
  logic [COLS-1:0]    col_q, col_d;
  logic               fs_q, fs_d;

  logic tc;
  logic blank_end;
  logic run;

  // Counting only happens while a scan is active and stays enabled; entering
  // from IDLE leaves the count at 0 so the first slot is full length.
  assign run = (state_q != ST_IDLE) && en;

  row_timer #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_row_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run),
    .tc_o        (tc),
    .blank_end_o (blank_end)
  );

  // Next state, row and latch. Outputs are derived from the next-state
  // values and then registered, so they change on the same edge as the
  // state and carry no combinational glitches.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    latch_d = latch_q;
    fs_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        row_d = '0;
        if (en) begin
          state_d = SLOT_START;
          latch_d = frame;
          fs_d    = 1'b1;
        end
      end

      ST_BLANK, ST_DRIVE: begin
        if (!en) begin
          state_d = ST_IDLE;
          row_d   = '0;
        end else if (tc) begin
          state_d = SLOT_START;
          if (row_q == ROW_W'(ROWS - 1)) begin
            row_d   = '0;
            latch_d = frame;
            fs_d    = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else if ((state_q == ST_BLANK) && blank_end) begin
          state_d = ST_DRIVE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        row_d   = '0;
      end
    endcase

    row_n_d = '1;
    col_d   = '0;
    if (state_d == ST_DRIVE) begin
      row_n_d = row_sel_n(row_d);
      col_d   = line_of(latch_d, row_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      latch_q <= '0;
      row_n_q <= '1;
      col_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      latch_q <= latch_d;
      row_n_q <= row_n_d;
      col_q   <= col_d;
      fs_q    <= fs_d;
    end
  end

  assign row_n       = row_n_q;
  assign col         = col_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb_matrix_scan_driver
// Two scanners share one stimulus stream: DIV=4/BLANK=1 and DIV=2/BLANK=0.
// A reference model per instance tracks the scan as elapsed clocks since
// the frame started; row and blank/drive phase follow from division of
// that time. Expected outputs are queued on each edge and a monitor pops
// and compares them on the falling edge.
module tb_matrix_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [34:0] frame = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] rowN;
    logic [4:0] col;
    logic       fs;
  } exp_t;

  typedef struct packed {
    logic        act;
    logic [31:0] t;
    logic [34:0] lat;
    logic        fs;
  } model_t;

  localparam exp_t IDLE_EXP = {7'h7F, 5'd0, 1'b0};

  always #5 clk = ~clk;

  // Advance the model by one clock: t counts clocks since the current
  // frame began; a whole frame is 7*div clocks.
  function automatic model_t step(input model_t s, input logic e,
                                  input logic [34:0] f, input int div);
    model_t r;
    r = s;
    r.fs = 1'b0;
    if (!s.act) begin
      if (e) begin
        r.act = 1'b1;
        r.t   = 0;
        r.lat = f;
        r.fs  = 1'b1;
      end
    end else if (!e) begin
      r.act = 1'b0;
      r.t   = 0;
    end else begin
      r.t = s.t + 1;
      if (r.t == 32'(7 * div)) begin
        r.t   = 0;
        r.lat = f;
        r.fs  = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic exp_t expectOut(input model_t s, input int div, input int blank);
    exp_t        e;
    int          pos;
    int          row;
    logic [34:0] sh;
    e = IDLE_EXP;
    e.fs = s.fs;
    if (s.act) begin
      pos = int'(s.t) % div;
      row = (int'(s.t) / div) % 7;
      if (pos >= blank) begin
        e.rowN = 7'h7F & ~(7'(1) << row);
        sh     = s.lat >> (5 * row);
        e.col  = sh[4:0];
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input int cfgIdx, input logic [6:0] rowN,
                             input logic [4:0] col, input logic fs, input exp_t e);
    checks++;
    if (rowN !== e.rowN || col !== e.col || fs !== e.fs) begin
      errors++;
      $display("[TB] FAIL cfg%0d outputs @%0t: got row_n=%b col=%b frame_start=%b, expected row_n=%b col=%b frame_start=%b",
               cfgIdx, $time, rowN, col, fs, e.rowN, e.col, e.fs);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int PDIV   = (g == 0) ? 4 : 2;
    localparam int PBLANK = (g == 0) ? 1 : 0;

    logic [6:0] rowN;
    logic [4:0] col;
    logic       fs;
    exp_t       expQ[$];
    model_t     m = '0;

    matrix_scan_driver #(
      .DIV   (PDIV),
      .BLANK (PBLANK)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .frame       (frame),
      .row_n       (rowN),
      .col         (col),
      .frame_start (fs)
    );

    // Reset drops any pending expectation: the outputs must go dark at once.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m <= '0;
        expQ.delete();
        expQ.push_back(IDLE_EXP);
      end else begin
        m <= step(m, en, frame, PDIV);
        expQ.push_back(expectOut(step(m, en, frame, PDIV), PDIV, PBLANK));
      end
    end

    always @(negedge clk) begin
      if (expQ.size() != 0) begin
        checkOutput(g, rowN, col, fs, expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic newEn, input logic [34:0] newFrame);
    @(posedge clk);
    #1;
    en    = newEn;
    frame = newFrame;
  endtask

  initial begin
    logic [34:0] f;
    logic        found;

    f        = '0;
    f[31:0]  = $urandom();
    f[34:32] = 3'($urandom());
    f[4:0]   = 5'b10101;
    f[9:5]   = 5'b01110;

    // Reset held with en already high: display must stay dark.
    rst_n = 1'b0;
    en    = 1'b1;
    frame = f;
    repeat (3) applyStimulus(1'b1, f);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Scan starts on the next edge; change line 0 while row 3 is showing.
    repeat (14) applyStimulus(1'b1, f);
    f[4:0] = 5'b11111;
    applyStimulus(1'b1, f);
    repeat (40) applyStimulus(1'b1, f);

    // Disable while the DIV=4 instance is driving row 2.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1;
      if (cfg[0].m.act && ((int'(cfg[0].m.t) / 4) % 7 == 2) && (int'(cfg[0].m.t) % 4 >= 1)) begin
        found = 1'b1;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL row2 wait: got no row-2 drive phase within 60 clocks, expected one");
    end
    en = 1'b0;
    repeat (3) applyStimulus(1'b0, f);
    applyStimulus(1'b1, f);
    repeat (30) applyStimulus(1'b1, f);

    // Asynchronous reset between edges, in the middle of a driven row.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random frames and occasional enable drops.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        f[31:0]  = $urandom();
        f[34:32] = 3'($urandom());
      end
      applyStimulus($urandom_range(0, 15) != 0, f);
    end

    repeat (3) @(posedge clk);
    #6;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_scan_driver.md
MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 Parameter DIV, default 50000: clocks per row slot; legal range 2..65535.
REQ-002 Parameter BLANK, default 8: blank (all rows off) clocks at the start of each row slot; legal range 0..DIV-1.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  scan enable; low = display dark.
REQ-006 frame  input  35  row patterns from the seven line-preset stages; frame[5r+4:5r] = line r (r=0..6); bit c = column c.
REQ-007 row_n  output  7  row select, one-hot active-low; bit r drives line r.
REQ-008 col  output  5  column data for the selected row, active-high.
REQ-009 frame_start  output  1  one-clock pulse when a new frame is latched.

Function
REQ-010 States: IDLE, BLANK, DRIVE; registers: row index (0..6), slot counter cnt (0..DIV-1), 35-bit frame latch.
REQ-011 IDLE: row_n=7'h7F, col=0, row=0, cnt=0; on a clock edge with en=1 -> BLANK (DRIVE if BLANK=0), latch frame, frame_start=1 for that one cycle.
REQ-012 cnt increments each clock in BLANK/DRIVE; BLANK -> DRIVE on the edge where cnt reaches BLANK.
REQ-013 BLANK: row_n=7'h7F, col=0.
REQ-014 DRIVE: row_n = ~(7'b1 << row), col = latch[5*row+4 : 5*row].
REQ-015 At cnt=DIV-1: cnt -> 0, row -> row+1, state -> BLANK (DRIVE if BLANK=0).
REQ-016 Wrap at row=6 and cnt=DIV-1: row -> 0, latch reloads from frame, frame_start=1 on the cycle row 0 begins.
REQ-017 frame changes outside the wrap edge have no effect on outputs until the next wrap (tear-free).
REQ-018 en sampled low in BLANK/DRIVE: next cycle IDLE, row_n=7'h7F, col=0; no frame_start.
REQ-019 Outputs are registered; never two rows asserted; row_n=7'h7F whenever col is not driven by DRIVE.
REQ-020 Row period = DIV clocks; frame period = 7*DIV clocks; duty per row = (DIV-BLANK)/(7*DIV).

Reset
REQ-021 rst_n low forces immediately, without clock: state IDLE, row_n=7'h7F, col=0, frame_start=0, row=0, cnt=0, latch=0.
REQ-022 After rst_n deasserts, scanning starts only on an edge with en=1 per REQ-011.

Structure
REQ-023 ROWS=7, COLS=5, and state encodings SHALL live in the shared package matrix_pkg, also used by the line-preset stages.
REQ-024 The slot counter with terminal-count and blank-end flags SHALL be a sub-module row_timer (parameters DIV, BLANK).
REQ-025 Counter width SHALL be clog2(DIV); no arithmetic wraps outside 0..DIV-1.

Verification (DIV=4, BLANK=1 unless stated)
REQ-026 Reset: rst_n=0 for 3 clocks, en=1 -> row_n=7'h7F, col=0, frame_start=0 throughout.
REQ-027 Scan: frame line0=5'b10101, line1=5'b01110, en rises -> frame_start=1 one cycle; 1 blank clock; 3 clocks row_n=7'b1111110, col=5'b10101; 1 blank; 3 clocks row_n=7'b1111101, col=5'b01110; frame_start again after 28 clocks.
REQ-028 Tear-free: change line0 to 5'b11111 while row=3 -> row 0 keeps showing 5'b10101 until the wrap; next frame row 0 shows 5'b11111.
REQ-029 Disable: en=0 during DRIVE of row 2 -> next cycle row_n=7'h7F, col=0; re-enable restarts at row 0 with frame_start=1.
REQ-030 Async reset: rst_n falls mid-DRIVE between clock edges -> row_n=7'h7F, col=0 before the next edge.
REQ-031 BLANK=0, DIV=2: no blank cycles; row_n steps 7'b1111110 -> 7'b1111101 every 2 clocks, one row active every cycle.
